// File: rtl/usb_pkg.sv
// usb_pkg: constants and types shared by the USB receive path.
//   SYNC_BYTE    - byte value that opens every packet
//   PID_*        - PID nibbles, compared against the upper nibble of the PID byte
//   rrcu_state_t - receive-control FSM state encoding
//   pid_class_t  - packet class decoded from a PID nibble
package usb_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'b1000_0000;

  localparam logic [3:0] PID_TOKEN  = 4'h4;
  localparam logic [3:0] PID_SOF    = 4'hA;
  localparam logic [3:0] PID_DATA   = 4'hC;
  localparam logic [3:0] PID_HSHAKE = 4'hD;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT_SYNC = 4'd1,
    ST_WAIT_PID  = 4'd2,
    ST_CHECK_PID = 4'd3,
    ST_RCV_ND    = 4'd4,
    ST_RCV_DATA  = 4'd5,
    ST_PUSH_CRC1 = 4'd6,
    ST_PUSH_CRC2 = 4'd7,
    ST_DONE      = 4'd8,
    ST_ERROR     = 4'd9,
    ST_EIDLE     = 4'd10
  } rrcu_state_t;

  typedef enum logic [1:0] {
    PC_TOKEN  = 2'd0,  // token or SOF: two non-data bytes follow
    PC_DATA   = 2'd1,
    PC_HSHAKE = 2'd2,  // nothing follows the PID
    PC_BAD    = 2'd3
  } pid_class_t;

  function automatic pid_class_t pid_class(input logic [3:0] nib);
    pid_class_t c;
    case (nib)
      PID_TOKEN, PID_SOF: c = PC_TOKEN;
      PID_DATA:           c = PC_DATA;
      PID_HSHAKE:         c = PC_HSHAKE;
      default:            c = PC_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rx_byte_delay.sv
// rx_byte_delay: two-entry byte delay line. Holds the most recent two bytes
// so the trailing CRC of a data packet can be told apart from payload.
//   clk, n_rst - clock, asynchronous active-low reset (clears contents)
//   load       - shift din in (oldest byte drops out when already full)
//   flush      - empty the line
//   din        - byte to load
//   count      - number of bytes held (0..2)
//   older      - earlier of the held bytes (valid when count >= 1)
//   newer      - later of the held bytes (valid when count == 2)
module rx_byte_delay (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [1:0] count,
  output logic [7:0] older,
  output logic [7:0] newer
);

  logic [1:0] count_q, count_d;
  logic [7:0] older_q, older_d;
  logic [7:0] newer_q, newer_d;

  always_comb begin
    count_d = count_q;
    older_d = older_q;
    newer_d = newer_q;
    if (flush) begin
      count_d = 2'd0;
      older_d = 8'h00;
      newer_d = 8'h00;
    end else if (load) begin
      case (count_q)
        2'd0: begin
          older_d = din;
          count_d = 2'd1;
        end
        2'd1: begin
          newer_d = din;
          count_d = 2'd2;
        end
        default: begin
          older_d = newer_q;
          newer_d = din;
          count_d = 2'd2;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= 2'd0;
      older_q <= 8'h00;
      newer_q <= 8'h00;
    end else begin
      count_q <= count_d;
      older_q <= older_d;
      newer_q <= newer_d;
    end
  end

  assign count = count_q;
  assign older = older_q;
  assign newer = newer_q;

endmodule

// File: rtl/rrcu.sv
// rrcu: USB receive-control unit. Walks a packet byte by byte, sorts bytes
// into the PID / non-data / data / data-CRC FIFOs and flags protocol errors.
//   MAX_DATA (<=127) - maximum payload bytes per DATA packet, CRC excluded
//   clk, n_rst       - clock, asynchronous active-low reset
//   d_edge           - start-of-packet line transition
//   rcv_data         - received byte, qualified by byte_received
//   byte_received    - one-cycle byte strobe
//   eop              - one-cycle end-of-packet strobe
//   *_full           - target FIFO full flags
//   write_data       - byte presented to the FIFOs
//   *_write          - one-cycle FIFO push strobes
//   rcving           - packet in progress
//   packet_done      - one-cycle pulse on error-free completion
//   r_error          - sticky error, cleared by the next d_edge after eop
// Build option: define RRCU_PID_CHECK_EN to reject PIDs whose low nibble is
// not the complement of the high nibble.
module rrcu
  import usb_pkg::*;
#(
  parameter int MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic [7:0] rcv_data,
  input  logic       byte_received,
  input  logic       eop,
  input  logic       pid_full,
  input  logic       nd_full,
  input  logic       data_full,
  input  logic       dcrc_full,
  output logic [7:0] write_data,
  output logic       pid_write,
  output logic       nd_write,
  output logic       data_write,
  output logic       dcrc_write,
  output logic       rcving,
  output logic       packet_done,
  output logic       r_error
);

  localparam logic [6:0] MAX_D7 = 7'(MAX_DATA);

  rrcu_state_t state_q, state_d;
  logic [3:0]  pid_nib_q, pid_nib_d;
  logic [1:0]  nd_exp_q, nd_exp_d;
  logic [1:0]  nd_cnt_q, nd_cnt_d;
  logic [6:0]  dat_cnt_q, dat_cnt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        pid_wr_q, pid_wr_d;
  logic        nd_wr_q, nd_wr_d;
  logic        dat_wr_q, dat_wr_d;
  logic        crc_wr_q, crc_wr_d;
  logic        rcving_q, rcving_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        dl_load, dl_flush;
  logic [1:0]  dl_count;
  logic [7:0]  dl_older, dl_newer;

  logic        pid_ok;
  logic        fail;
  logic        collide;
  logic        pkt_over;

  rx_byte_delay u_delay (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (dl_load),
    .flush (dl_flush),
    .din   (rcv_data),
    .count (dl_count),
    .older (dl_older),
    .newer (dl_newer)
  );

  // The PID push must land one cycle after the PID byte, so the integrity
  // check is applied as the byte arrives rather than one cycle later.
`ifdef RRCU_PID_CHECK_EN
  assign pid_ok = (rcv_data[3:0] == ~rcv_data[7:4]);
`else
  assign pid_ok = 1'b1;
`endif

  assign collide  = byte_received & eop;
  // Once eop has been seen there is no further eop to wait for in ERROR.
  assign pkt_over = eop | (state_q == ST_PUSH_CRC1);

  always_comb begin
    state_d   = state_q;
    pid_nib_d = pid_nib_q;
    nd_exp_d  = nd_exp_q;
    nd_cnt_d  = nd_cnt_q;
    dat_cnt_d = dat_cnt_q;
    wdata_d   = wdata_q;
    pid_wr_d  = 1'b0;
    nd_wr_d   = 1'b0;
    dat_wr_d  = 1'b0;
    crc_wr_d  = 1'b0;
    done_d    = 1'b0;
    rcving_d  = rcving_q;
    err_d     = err_q;
    dl_load   = 1'b0;
    dl_flush  = 1'b0;
    fail      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_edge) state_d = ST_WAIT_SYNC;
      end

      ST_WAIT_SYNC: begin
        if (collide || eop) begin
          fail = 1'b1;
        end else if (byte_received) begin
          if (rcv_data == SYNC_BYTE) begin
            rcving_d = 1'b1;
            state_d  = ST_WAIT_PID;
          end else begin
            fail = 1'b1;
          end
        end
      end

      ST_WAIT_PID: begin
        if (collide || eop) begin
          fail = 1'b1;
        end else if (byte_received) begin
          if (!pid_ok || pid_full) begin
            fail = 1'b1;
          end else begin
            pid_wr_d  = 1'b1;
            wdata_d   = rcv_data;
            pid_nib_d = rcv_data[7:4];
            state_d   = ST_CHECK_PID;
          end
        end
      end

      // Decode cycle; bytes are many clocks apart so any event here is a
      // framing fault.
      ST_CHECK_PID: begin
        dl_flush  = 1'b1;
        nd_cnt_d  = 2'd0;
        dat_cnt_d = 7'd0;
        if (byte_received || eop) begin
          fail = 1'b1;
        end else begin
          case (pid_class(pid_nib_q))
            PC_TOKEN: begin
              nd_exp_d = 2'd2;
              state_d  = ST_RCV_ND;
            end
            PC_HSHAKE: begin
              nd_exp_d = 2'd0;
              state_d  = ST_RCV_ND;
            end
            PC_DATA: state_d = ST_RCV_DATA;
            default: fail = 1'b1;
          endcase
        end
      end

      ST_RCV_ND: begin
        if (collide) begin
          fail = 1'b1;
        end else if (byte_received) begin
          if (nd_cnt_q == nd_exp_q || nd_full) begin
            fail = 1'b1;
          end else begin
            nd_wr_d  = 1'b1;
            wdata_d  = rcv_data;
            nd_cnt_d = nd_cnt_q + 2'd1;
          end
        end else if (eop) begin
          if (nd_cnt_q == nd_exp_q) begin
            done_d   = 1'b1;
            rcving_d = 1'b0;
            state_d  = ST_DONE;
          end else begin
            fail = 1'b1;
          end
        end
      end

      // The newest two bytes are always held back: they become the CRC if
      // eop follows, otherwise the older one is payload.
      ST_RCV_DATA: begin
        if (collide) begin
          fail = 1'b1;
        end else if (byte_received) begin
          if (dl_count == 2'd2) begin
            // Counter only advances below MAX_DATA, so it cannot wrap.
            if (dat_cnt_q >= MAX_D7 || data_full) begin
              fail = 1'b1;
            end else begin
              dat_wr_d  = 1'b1;
              wdata_d   = dl_older;
              dat_cnt_d = dat_cnt_q + 7'd1;
              dl_load   = 1'b1;
            end
          end else begin
            dl_load = 1'b1;
          end
        end else if (eop) begin
          if (dl_count != 2'd2 || dcrc_full) begin
            fail = 1'b1;
          end else begin
            crc_wr_d = 1'b1;
            wdata_d  = dl_older;
            state_d  = ST_PUSH_CRC1;
          end
        end
      end

      ST_PUSH_CRC1: begin
        if (dcrc_full) begin
          fail = 1'b1;
        end else begin
          crc_wr_d = 1'b1;
          wdata_d  = dl_newer;
          state_d  = ST_PUSH_CRC2;
        end
      end

      ST_PUSH_CRC2: begin
        done_d   = 1'b1;
        rcving_d = 1'b0;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        if (eop) state_d = ST_EIDLE;
      end

      ST_EIDLE: begin
        if (d_edge) begin
          err_d   = 1'b0;
          state_d = ST_WAIT_SYNC;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      err_d    = 1'b1;
      rcving_d = 1'b0;
      state_d  = pkt_over ? ST_EIDLE : ST_ERROR;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      pid_nib_q <= 4'h0;
      nd_exp_q  <= 2'd0;
      nd_cnt_q  <= 2'd0;
      dat_cnt_q <= 7'd0;
      wdata_q   <= 8'h00;
      pid_wr_q  <= 1'b0;
      nd_wr_q   <= 1'b0;
      dat_wr_q  <= 1'b0;
      crc_wr_q  <= 1'b0;
      rcving_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pid_nib_q <= pid_nib_d;
      nd_exp_q  <= nd_exp_d;
      nd_cnt_q  <= nd_cnt_d;
      dat_cnt_q <= dat_cnt_d;
      wdata_q   <= wdata_d;
      pid_wr_q  <= pid_wr_d;
      nd_wr_q   <= nd_wr_d;
      dat_wr_q  <= dat_wr_d;
      crc_wr_q  <= crc_wr_d;
      rcving_q  <= rcving_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign write_data  = wdata_q;
  assign pid_write   = pid_wr_q;
  assign nd_write    = nd_wr_q;
  assign data_write  = dat_wr_q;
  assign dcrc_write  = crc_wr_q;
  assign rcving      = rcving_q;
  assign packet_done = done_q;
  assign r_error     = err_q;

endmodule

// File: tb/tb_rrcu.sv
// tb_rrcu: scoreboard bench for rrcu. Each packet is turned into its expected
// list of FIFO pushes / completion by a list-level model; a negedge monitor
// pops and compares every strobe the DUT presents.
module tb_rrcu;

  localparam int MAXD = 64;
  localparam logic [3:0] EV_PID = 4'd1, EV_ND = 4'd2, EV_DAT = 4'd3,
                         EV_CRC = 4'd4, EV_DONE = 4'd5;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       byte_received = 1'b0;
  logic       eop = 1'b0;
  logic       pid_full = 1'b0, nd_full = 1'b0, data_full = 1'b0, dcrc_full = 1'b0;
  logic [7:0] write_data;
  logic       pid_write, nd_write, data_write, dcrc_write;
  logic       rcving, packet_done, r_error;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_act, mon_exp;
  logic [4:0]  mon_s;

  rrcu #(.MAX_DATA(MAXD)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .rcv_data(rcv_data),
    .byte_received(byte_received), .eop(eop),
    .pid_full(pid_full), .nd_full(nd_full), .data_full(data_full), .dcrc_full(dcrc_full),
    .write_data(write_data), .pid_write(pid_write), .nd_write(nd_write),
    .data_write(data_write), .dcrc_write(dcrc_write),
    .rcving(rcving), .packet_done(packet_done), .r_error(r_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next expected event.
  always @(negedge clk) begin
    mon_s = {packet_done, dcrc_write, data_write, nd_write, pid_write};
    if (mon_s != 5'b0) begin
      if ($countones(mon_s) != 1) begin
        checks++; failures++;
        $display("FAIL strobe_onehot: got %b expected one strobe", mon_s);
      end else if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_event: got strobes %b data %h expected none", mon_s, write_data);
      end else begin
        if (pid_write)       mon_act = {EV_PID, write_data};
        else if (nd_write)   mon_act = {EV_ND, write_data};
        else if (data_write) mon_act = {EV_DAT, write_data};
        else if (dcrc_write) mon_act = {EV_CRC, write_data};
        else                 mon_act = {EV_DONE, 8'h00};
        mon_exp = exp_q.pop_front();
        chk("event", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  // Reference model: expected pushes for a whole packet, from the packet rules.
  task automatic model(input logic [7:0] sync, input logic [7:0] pid, input logic [7:0] b[$],
                       input bit collide, input bit pfull, input bit dfull, output bit err);
    logic [7:0] body[$];
    logic [3:0] hi;
    int n, pay, sz;
    err = 1'b0;
    body = b;
    if (collide) void'(body.pop_back());
    sz = body.size();
    if (sync != 8'h80) begin err = 1'b1; return; end
`ifdef RRCU_PID_CHECK_EN
    if (pid[3:0] != ~pid[7:4]) begin err = 1'b1; return; end
`endif
    if (pfull) begin err = 1'b1; return; end
    exp_q.push_back({EV_PID, pid});
    hi = pid[7:4];
    if (hi == 4'h4 || hi == 4'hA || hi == 4'hD) begin
      n = (hi == 4'hD) ? 0 : 2;
      for (int i = 0; i < sz && i < n; i++) exp_q.push_back({EV_ND, body[i]});
      if (sz != n || collide) err = 1'b1;
      else exp_q.push_back({EV_DONE, 8'h00});
    end else if (hi == 4'hC) begin
      pay = sz - 2;
      if (pay > MAXD) begin
        for (int i = 0; i < MAXD; i++) exp_q.push_back({EV_DAT, body[i]});
        err = 1'b1;
      end else if (dfull && pay >= 1) begin
        err = 1'b1;
      end else begin
        for (int i = 0; i < pay; i++) exp_q.push_back({EV_DAT, body[i]});
        if (collide || sz < 2) err = 1'b1;
        else begin
          exp_q.push_back({EV_CRC, body[sz-2]});
          exp_q.push_back({EV_CRC, body[sz-1]});
          exp_q.push_back({EV_DONE, 8'h00});
        end
      end
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit with_eop);
    @(posedge clk); #1;
    rcv_data = v; byte_received = 1'b1; eop = with_eop;
    @(posedge clk); #1;
    byte_received = 1'b0; eop = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_eop();
    @(posedge clk); #1;
    eop = 1'b1;
    @(posedge clk); #1;
    eop = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_d_edge();
    @(posedge clk); #1;
    d_edge = 1'b1;
    @(posedge clk); #1;
    d_edge = 1'b0;
    chk("r_error_cleared_by_d_edge", 32'(r_error), 32'd0);
  endtask

  task automatic run_packet(input logic [7:0] sync, input logic [7:0] pid, input logic [7:0] b[$],
                            input bit collide, input bit pfull, input bit dfull);
    bit err;
    pid_full = pfull; data_full = dfull;
    model(sync, pid, b, collide, pfull, dfull, err);
    pulse_d_edge();
    send_byte(sync, 1'b0);
    #1 chk("rcving_after_sync", 32'(rcving), 32'(sync == 8'h80));
    send_byte(pid, 1'b0);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], collide && (i == b.size() - 1));
    if (!collide) send_eop();
    repeat (6) @(posedge clk); #1;
    chk("events_drained", 32'(exp_q.size()), 32'd0);
    chk("r_error_end", 32'(r_error), 32'(err));
    chk("rcving_end", 32'(rcving), 32'd0);
    exp_q.delete();
    pid_full = 1'b0; data_full = 1'b0;
  endtask

  task automatic reset_mid_data();
    exp_q.push_back({EV_PID, 8'hC3});
    exp_q.push_back({EV_DAT, 8'hA0});
    pulse_d_edge();
    send_byte(8'h80, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    #2 chk("rcving_mid_data", 32'(rcving), 32'd1);
    n_rst = 1'b0;
    #1 chk("outputs_on_async_reset",
           32'({write_data, pid_write, nd_write, data_write, dcrc_write, rcving, packet_done, r_error}),
           32'd0);
    chk("events_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int kind, len;
    logic [3:0] hi, lo;
    logic [7:0] sync;
    bit col;

    repeat (3) @(posedge clk);
    #1 chk("outputs_in_reset",
           32'({write_data, pid_write, nd_write, data_write, dcrc_write, rcving, packet_done, r_error}),
           32'd0);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    q = {8'h11, 8'h22};
    run_packet(8'h80, 8'h4B, q, 0, 0, 0);
    q = {8'hA0, 8'hA1, 8'hA2, 8'hC1, 8'hC2};
    run_packet(8'h80, 8'hC3, q, 0, 0, 0);
    q = {};
    run_packet(8'h80, 8'hD2, q, 0, 0, 0);
    q = {8'h55};
    run_packet(8'h80, 8'hD2, q, 0, 0, 0);
    q = {8'h01, 8'h02};
    run_packet(8'h81, 8'h4B, q, 0, 0, 0);
    q = {8'h01, 8'h02, 8'h03};
    run_packet(8'h80, 8'hC4, q, 0, 0, 0);
    q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_packet(8'h80, 8'hC3, q, 0, 0, 1);
    q = {};
    for (int i = 0; i < 67; i++) q.push_back(8'(i + 1));
    run_packet(8'h80, 8'hC3, q, 0, 0, 0);
    q = {};
    for (int i = 0; i < 66; i++) q.push_back(8'(8'hF0 - i));
    run_packet(8'h80, 8'hC3, q, 0, 0, 0);
    q = {8'h11};
    run_packet(8'h80, 8'h4B, q, 0, 0, 0);
    q = {8'h11, 8'h22};
    run_packet(8'h80, 8'h4B, q, 1, 0, 0);
    q = {8'hAA};
    run_packet(8'h80, 8'hC3, q, 0, 0, 0);
    q = {8'h11, 8'h22};
    run_packet(8'h80, 8'h4B, q, 0, 1, 0);
    q = {8'h11, 8'h22};
    run_packet(8'h80, 8'h1E, q, 0, 0, 0);

    reset_mid_data();
    q = {8'hB0, 8'hB1, 8'hB2, 8'hB3};
    run_packet(8'h80, 8'hC3, q, 0, 0, 0);

    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1:    hi = 4'h4;
        2:       hi = 4'hA;
        3, 4, 5: hi = 4'hC;
        6, 7:    hi = 4'hD;
        default: hi = 4'($urandom);
      endcase
      lo = ($urandom_range(0, 99) < 15) ? 4'($urandom) : ~hi;
      if (hi == 4'hC) begin
        if ($urandom_range(0, 19) == 0) len = $urandom_range(65, 69);
        else if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 1);
        else len = $urandom_range(2, 10);
      end else if (hi == 4'hD) begin
        len = ($urandom_range(0, 4) == 0) ? 1 : 0;
      end else begin
        len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 2;
      end
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      sync = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h80;
      col = (len >= 1) && ($urandom_range(0, 19) == 0);
      run_packet(sync, {hi, lo}, q, col,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
